// File: rtl/mem_access_ctrl.sv
// Requester-side controller for the byte/half/word data RAM: validates one load/store at a time,
// drives the RAM port for a single cycle and returns the extended load result over a valid/ready handshake.
module mem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned SIZE_BYTES = 1024
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [11:0] ram_addr,
   output logic [1:0]  ram_mode,
   output logic [31:0] ram_data_in,
   output logic        ram_memWrite,
   output logic        ram_sel,
   input  logic [31:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [11:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] offset;
   logic        req_err;
   logic [31:0] load_ext;

   // The window check relies on unsigned subtraction; addresses below the base are rejected separately
   // so a wrapped offset can never alias into the window.
   always_comb begin
      offset  = req_addr - BASE_ADDR;
      req_err = (req_size == 2'b11)
              | ((req_size == 2'b01) & req_addr[0])
              | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
              | (req_addr < BASE_ADDR)
              | (offset >= 32'(SIZE_BYTES));
   end

   always_comb begin
      load_ext = ram_data_out;
      if (signed_q && size_q == 2'b00)
         load_ext = {{24{ram_data_out[7]}}, ram_data_out[7:0]};
      else if (signed_q && size_q == 2'b01)
         load_ext = {{16{ram_data_out[15]}}, ram_data_out[15:0]};
   end

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      size_d   = size_q;
      signed_d = signed_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = offset[11:0];
               wdata_d  = req_wdata;
               rdata_d  = 32'h0;
               err_d    = req_err;
               state_d  = req_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            rdata_d = write_q ? 32'h0 : load_ext;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         size_q   <= 2'b10;
         signed_q <= 1'b0;
         addr_q   <= 12'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         size_q   <= size_d;
         signed_q <= signed_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // RAM strobes are decoded from the state flop so they drop the instant clr asserts.
   assign req_ready    = (state_q == IDLE);
   assign resp_valid   = (state_q == RESP);
   assign resp_rdata   = rdata_q;
   assign resp_err     = err_q;
   assign ram_sel      = (state_q == ACCESS);
   assign ram_memWrite = (state_q == ACCESS) & write_q;
   assign ram_addr     = addr_q;
   assign ram_mode     = size_q;
   assign ram_data_in  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a little-endian byte RAM model plus a table of load/store vectors
// and hand-written sequences for response back-pressure and reset during an access.
module tb_mem_access_ctrl;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        clr;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [11:0] ram_addr;
   logic [1:0]  ram_mode;
   logic [31:0] ram_data_in, ram_data_out;
   logic        ram_memWrite, ram_sel;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [1024];

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] expData;
      logic        expErr;
   } vec_t;

   vec_t vecs [20];

   mem_access_ctrl #(.BASE_ADDR(BASE), .SIZE_BYTES(1024)) dut (
      .clk(clk), .clr(clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .ram_addr(ram_addr), .ram_mode(ram_mode), .ram_data_in(ram_data_in),
      .ram_memWrite(ram_memWrite), .ram_sel(ram_sel), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   // Little-endian data RAM: synchronous write, combinational zero-extended read, cleared by clr.
   always @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else if (ram_sel && ram_memWrite) begin
         mem[int'(ram_addr[9:0])] <= ram_data_in[7:0];
         if (ram_mode != 2'b00) mem[int'(ram_addr[9:0] + 10'd1)] <= ram_data_in[15:8];
         if (ram_mode == 2'b10) begin
            mem[int'(ram_addr[9:0] + 10'd2)] <= ram_data_in[23:16];
            mem[int'(ram_addr[9:0] + 10'd3)] <= ram_data_in[31:24];
         end
      end
   end

   always_comb begin
      ram_data_out = 32'h0;
      case (ram_mode)
         2'b00:   ram_data_out = {24'h0, mem[int'(ram_addr[9:0])]};
         2'b01:   ram_data_out = {16'h0, mem[int'(ram_addr[9:0] + 10'd1)], mem[int'(ram_addr[9:0])]};
         default: ram_data_out = {mem[int'(ram_addr[9:0] + 10'd3)], mem[int'(ram_addr[9:0] + 10'd2)],
                                  mem[int'(ram_addr[9:0] + 10'd1)], mem[int'(ram_addr[9:0])]};
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one request with resp_ready high, scramble the request inputs after acceptance and check
   // latency, the single RAM access cycle, and the returned data/error.
   task automatic applyStimulus(input vec_t v);
      int lat;
      int selCnt;
      logic [31:0] off;
      off = v.addr - BASE;
      checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_write  = v.wr;
      req_size   = v.size;
      req_signed = v.sgn;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid  = 1'b0;
      req_write  = ~v.wr;
      req_size   = ~v.size;
      req_signed = ~v.sgn;
      req_addr   = ~v.addr;
      req_wdata  = ~v.wdata;
      lat = 0;
      selCnt = 0;
      while (!resp_valid && lat < 8) begin
         if (ram_sel) begin
            selCnt++;
            checkOutput("ram_we", 32'(ram_memWrite), 32'(v.wr));
            checkOutput("ram_addr", 32'(ram_addr), 32'(off[11:0]));
            checkOutput("ram_mode", 32'(ram_mode), 32'(v.size));
            if (v.wr) checkOutput("ram_wdata", ram_data_in, v.wdata);
         end
         @(negedge clk);
         lat++;
      end
      checkOutput("resp_valid", 32'(resp_valid), 32'd1);
      checkOutput("latency", 32'(lat), v.expErr ? 32'd0 : 32'd1);
      checkOutput("sel_cycles", 32'(selCnt), v.expErr ? 32'd0 : 32'd1);
      checkOutput("sel_in_resp", 32'(ram_sel), 32'd0);
      checkOutput("resp_err", 32'(resp_err), 32'(v.expErr));
      checkOutput("resp_rdata", resp_rdata, v.expData);
      @(negedge clk);
      checkOutput("resp_done", 32'(resp_valid), 32'd0);
      checkOutput("ready_again", 32'(req_ready), 32'd1);
   endtask

   task automatic checkReset();
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_rdata", resp_rdata, 32'd0);
      checkOutput("rst_err", 32'(resp_err), 32'd0);
      checkOutput("rst_sel", 32'(ram_sel), 32'd0);
      checkOutput("rst_we", 32'(ram_memWrite), 32'd0);
      checkOutput("rst_mode", 32'(ram_mode), 32'd2);
      checkOutput("rst_addr", 32'(ram_addr), 32'd0);
      checkOutput("rst_wdata", ram_data_in, 32'd0);
   endtask

   initial begin
      int n;
      vecs[0]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h010, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, BASE + 32'h013, 32'h12345680, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 2'b00, 1'b1, BASE + 32'h013, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, BASE + 32'h013, 32'h0,        32'h0000_0080, 1'b0};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h010, 32'h0,        32'h80ADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 2'b01, 1'b0, BASE + 32'h021, 32'h1111_2222, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b1, 2'b10, 1'b0, BASE + 32'h022, 32'h3333_4444, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h020, 32'h0,        32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, BASE + 32'h400, 32'h0,        32'h0000_0000, 1'b1};
      vecs[10] = '{1'b0, 2'b11, 1'b0, BASE,           32'h0,        32'h0000_0000, 1'b1};
      vecs[11] = '{1'b1, 2'b01, 1'b0, BASE + 32'h030, 32'hABCD8001, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 2'b01, 1'b1, BASE + 32'h030, 32'h0,        32'hFFFF8001, 1'b0};
      vecs[13] = '{1'b0, 2'b01, 1'b0, BASE + 32'h030, 32'h0,        32'h0000_8001, 1'b0};
      vecs[14] = '{1'b1, 2'b10, 1'b0, BASE + 32'h3FC, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
      vecs[15] = '{1'b0, 2'b00, 1'b0, BASE + 32'h3FF, 32'h0,        32'h0000_00CA, 1'b0};
      vecs[16] = '{1'b0, 2'b00, 1'b1, BASE - 32'h001, 32'h0,        32'h0000_0000, 1'b1};
      vecs[17] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC,  32'h0,        32'h0000_0000, 1'b1};
      vecs[18] = '{1'b0, 2'b01, 1'b1, BASE + 32'h012, 32'h0,        32'hFFFF80AD, 1'b0};
      vecs[19] = '{1'b1, 2'b10, 1'b0, BASE + 32'h400, 32'h5555_AAAA, 32'h0000_0000, 1'b1};

      clr = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
      #12;
      checkReset();
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 20; i++) applyStimulus(vecs[i]);

      // Back-pressure: response must hold for five stalled cycles while a competing request is ignored.
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = BASE + 32'h010; resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_write = 1'b1; req_wdata = 32'h0BAD_0BAD;
      n = 0;
      while (!resp_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      checkOutput("stall_lat", 32'(n), 32'd1);
      for (int c = 0; c < 5; c++) begin
         checkOutput("stall_valid", 32'(resp_valid), 32'd1);
         checkOutput("stall_rdata", resp_rdata, 32'h80ADBEEF);
         checkOutput("stall_ready", 32'(req_ready), 32'd0);
         checkOutput("stall_sel", 32'(ram_sel), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall_done", 32'(resp_valid), 32'd0);
      checkOutput("stall_accept", 32'(req_ready), 32'd1);
      applyStimulus('{1'b0, 2'b10, 1'b0, BASE + 32'h010, 32'h0, 32'h80ADBEEF, 1'b0});

      // Reset in the middle of a store access: strobes drop at once and nothing is written.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = BASE + 32'h040; req_wdata = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("pre_clr_sel", 32'(ram_sel), 32'd1);
      checkOutput("pre_clr_we", 32'(ram_memWrite), 32'd1);
      #1 clr = 1'b1;
      #1;
      checkReset();
      @(negedge clk);
      clr = 1'b0;
      @(negedge clk);
      checkOutput("post_clr_valid", 32'(resp_valid), 32'd0);
      applyStimulus('{1'b0, 2'b10, 1'b0, BASE + 32'h040, 32'h0, 32'h0000_0000, 1'b0});
      applyStimulus('{1'b0, 2'b10, 1'b0, BASE + 32'h010, 32'h0, 32'h0000_0000, 1'b0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
